// File: rtl/rect_filler.sv
// rtl/rect_filler.sv - solid rectangle writer, one framebuffer pixel per clock, row-major.
// Optional build macro RECT_FILLER_CLIP_EN suppresses writes outside SCREEN_W x SCREEN_H.
module rect_filler #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SZ_W     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      refX,
  input  logic [Y_W-1:0]      refY,
  input  logic [SZ_W-1:0]     width,
  input  logic [SZ_W-1:0]     height,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

`ifdef RECT_FILLER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, DRAW} state_t;

  state_t              state, state_nxt;
  logic [X_W-1:0]      ref_x, ref_x_nxt;
  logic [Y_W-1:0]      ref_y, ref_y_nxt;
  logic [SZ_W-1:0]     rect_w, rect_w_nxt;
  logic [SZ_W-1:0]     rect_h, rect_h_nxt;
  logic [COLOUR_W-1:0] rect_col, rect_col_nxt;
  logic [SZ_W-1:0]     cx, cx_nxt;
  logic [SZ_W-1:0]     cy, cy_nxt;
  logic [X_W-1:0]      x_nxt;
  logic [Y_W-1:0]      y_nxt;
  logic [COLOUR_W-1:0] colour_nxt;
  logic                we_nxt, busy_nxt, done_nxt;

  // One guard bit above the coordinate so off-screen pixels are detectable before wrap.
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic         last_col, last_row, on_screen;

  assign px       = {1'b0, ref_x} + (X_W+1)'(cx);
  assign py       = {1'b0, ref_y} + (Y_W+1)'(cy);
  assign last_col = (cx == rect_w - SZ_W'(1));
  assign last_row = (cy == rect_h - SZ_W'(1));
  assign on_screen = CLIP_EN ? ((px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H))) : 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      ref_x    <= '0;
      ref_y    <= '0;
      rect_w   <= '0;
      rect_h   <= '0;
      rect_col <= '0;
      cx       <= '0;
      cy       <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      writeEn  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b1;
    end else begin
      state    <= state_nxt;
      ref_x    <= ref_x_nxt;
      ref_y    <= ref_y_nxt;
      rect_w   <= rect_w_nxt;
      rect_h   <= rect_h_nxt;
      rect_col <= rect_col_nxt;
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      x        <= x_nxt;
      y        <= y_nxt;
      colour   <= colour_nxt;
      writeEn  <= we_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ref_x_nxt    = ref_x;
    ref_y_nxt    = ref_y;
    rect_w_nxt   = rect_w;
    rect_h_nxt   = rect_h;
    rect_col_nxt = rect_col;
    cx_nxt       = cx;
    cy_nxt       = cy;
    x_nxt        = '0;
    y_nxt        = '0;
    colour_nxt   = '0;
    we_nxt       = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b1;

    // start outranks abort and also restarts a rectangle already being drawn.
    if (start) begin
      ref_x_nxt    = refX;
      ref_y_nxt    = refY;
      rect_w_nxt   = width;
      rect_h_nxt   = height;
      rect_col_nxt = fill_colour;
      cx_nxt       = '0;
      cy_nxt       = '0;
      if (width != '0 && height != '0) begin
        state_nxt = DRAW;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state == DRAW) begin
      if (abort) begin
        state_nxt = IDLE;
      end else begin
        x_nxt      = px[X_W-1:0];
        y_nxt      = py[Y_W-1:0];
        colour_nxt = rect_col;
        we_nxt     = on_screen;
        busy_nxt   = 1'b1;
        done_nxt   = 1'b0;
        if (last_col) begin
          cx_nxt = '0;
          cy_nxt = cy + SZ_W'(1);
          if (last_row) state_nxt = IDLE;
        end else begin
          cx_nxt = cx + SZ_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/rect_filler.md
Name: rect_filler

Overview:
- Parametrised rectangle writer for the graphics FSM. Successor to the fixed 8x8 black clearer.
- On a start pulse it latches origin, size and colour. It then emits one framebuffer write per cycle, row-major, on the VGA adapter pixel interface.
- Used for clearing sprite footprints, drawing solid blocks and background fills.

Parameters:
- X_W, 8, width of x coordinate.
- Y_W, 7, width of y coordinate.
- COLOUR_W, 3, colour bits per pixel.
- SZ_W, 4, width of size inputs; max rectangle dimension 2^SZ_W-1.
- SCREEN_W, 160, visible columns (used only with CLIP_EN).
- SCREEN_H, 120, visible rows (used only with CLIP_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; latches inputs below.
- abort  in  1  terminate current rectangle.
- refX  in  X_W  top-left x.
- refY  in  Y_W  top-left y.
- width  in  SZ_W  rectangle width in pixels.
- height  in  SZ_W  rectangle height in pixels.
- fill_colour  in  COLOUR_W  pixel colour.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  COLOUR_W  pixel colour.
- writeEn  out  1  pixel write strobe.
- busy  out  1  rectangle in progress.
- done  out  1  idle/complete level.

Behaviour:
- Reset (reset_n=0 on a rising edge): state IDLE; x=0, y=0, colour=0, writeEn=0, busy=0, done=1; counters cleared. Applies mid-rectangle too; no further writes.
- All outputs are registered.
- States: IDLE, DRAW.
- IDLE:
  - start=1 latches refX, refY, width, height and fill_colour.
  - Clears the column counter cx and row counter cy to 0.
  - If width=0 or height=0, stays IDLE: done stays 1, no writes.
  - Otherwise goes to DRAW: busy=1, done=0 on the next edge.
- DRAW, each cycle:
  - Outputs x=refX+cx and y=refY+cy, both truncated to X_W/Y_W (modulo wrap); colour=latched colour; writeEn=1.
  - cx increments. When cx reaches width-1, cx returns to 0 and cy increments.
- Latency and throughput:
  - Start edge is cycle 0; first write is visible after edge 1.
  - Writes arrive on W*H consecutive cycles, one pixel per clock, no gaps.
- Completion: the edge after the last pixel (cx=width-1, cy=height-1) returns to IDLE. writeEn=0, busy=0, done=1, x/y/colour=0.
- start during DRAW: restarts. The edge that samples start drops writeEn, reloads inputs and clears counters. Writes resume the following cycle at the new origin.
- abort during DRAW (start=0): next edge returns to IDLE, writeEn=0, done=1.
- start and abort together: start wins.
- abort in IDLE: ignored.
- Input changes after the start edge have no effect on the rectangle in progress.
- done is a level, not a pulse.

Optional Feature:
- Macro: RECT_FILLER_CLIP_EN.
- Defined:
  - Pixel coordinates are computed at X_W+1/Y_W+1 bits.
  - Any pixel with x>=SCREEN_W or y>=SCREEN_H is emitted with writeEn=0, but still consumes its cycle, so timing is identical. x/y on such cycles are don't-care.
- Not defined: coordinates wrap modulo 2^X_W / 2^Y_W, and every pixel is written.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles -> x=0, y=0, colour=0, writeEn=0, busy=0, done=1.
- Basic fill: start with refX=10, refY=20, width=3, height=2, colour=5 -> exactly 6 consecutive writes (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour=5. First write after edge 1; done=1 after edge 7.
- Zero size: width=0, height=4, start -> no writeEn ever asserted, done stays 1, busy stays 0.
- Restart and abort:
  - Start 4x4 at (0,0); after 5 writes, start 2x1 at (50,50), colour 2 -> one writeEn=0 cycle, then writes (50,50),(51,50), done.
  - Separately, abort after 3 writes -> writeEn=0 next cycle, done=1.
- Reset mid-operation: reset_n=0 during 15x15 fill -> writeEn=0, done=1 after that edge; no writes once reset_n is released.
- Edge clipping: refX=158, refY=119, width=3, height=2 ->
  - With RECT_FILLER_CLIP_EN: writes only (158,119),(159,119); 6 cycles total.
  - Without it: 6 writes, x wrapping 158,159,160 and row-1 y=120.
